mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration, in cycles, of mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration, in cycles, of div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  issue strobe from E stage; sampled each rising edge.
REQ-006 op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 cancel  input  1  exception/flush in E stage; suppresses the start sampled in the same cycle.
REQ-008 a  input  32  rs operand.
REQ-009 b  input  32  rt operand.
REQ-010 busy  output  1  registered; high while a mult/div is in flight.
REQ-011 hi  output  32  registered HI register.
REQ-012 lo  output  32  registered LO register.
REQ-013 done  output  1  registered one-cycle pulse on the edge HI/LO take a mult/div result.

Function
REQ-014 State machine SHALL have two states: IDLE (busy=0) and RUN (busy=1), with a down-counter cnt wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 Accept condition: start=1, cancel=0, state IDLE, op in 1..6.
REQ-016 Accepted mult/multu/div/divu SHALL latch a, b and op, load cnt with the op's cycle count, and enter RUN at that same edge.
REQ-017 busy SHALL be high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) starting the cycle after the accepting edge.
REQ-018 In RUN, cnt SHALL decrement each edge; on the edge where cnt goes 1->0, HI/LO SHALL update, done SHALL pulse, and the state SHALL return to IDLE.
REQ-019 New HI/LO SHALL be visible in the first cycle with busy=0; the result is computed from the latched operands only, so later changes on a/b have no effect.
REQ-020 mult: {hi,lo} = signed(a)*signed(b), 64-bit; multu: unsigned 64-bit product.
REQ-021 div: lo = signed quotient truncated toward zero; hi = remainder with the dividend's sign.
REQ-022 divu: lo = unsigned quotient; hi = unsigned remainder.
REQ-023 Divide by zero (b=0) SHALL run the full DIV_CYCLES, and HI/LO SHALL remain unchanged; done still pulses.
REQ-024 div with 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-025 Accepted mthi/mtlo SHALL write a into hi/lo at the accepting edge, with no busy and no done.
REQ-026 start while busy=1 SHALL be ignored with no effect on state, counter, latched operands or HI/LO; the hazard unit guarantees this does not occur in legal flow.
REQ-027 cancel=1 SHALL block only a same-cycle start; an operation already in RUN SHALL complete normally.
REQ-028 op 0 or 7 with start=1 SHALL be a no-op.
REQ-029 done SHALL be 0 in every cycle except the completion cycle.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, and clear latched operands.
REQ-031 reset SHALL take priority over start, cancel and completion in the same edge.
REQ-032 Reset mid-RUN SHALL discard the in-flight result, and HI/LO SHALL not update afterwards.

Verification
REQ-033 mult with a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
REQ-034 multu with a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 div with a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu with a=7, b=0 -> hi/lo unchanged, done pulses.
REQ-036 mthi a=0x12345678 then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo update at each edge; busy stays 0.
REQ-037 mult started with cancel=1 -> busy stays 0 and HI/LO unchanged. Second start issued during busy -> ignored, and the first result is committed.
REQ-038 div accepted, reset asserted on the 4th busy cycle -> next cycle busy=0, hi=lo=0, and no done pulse follows.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency mult/div sequencing with HI/LO
// result registers and direct mthi/mtlo writes.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [31:0]       a_r, a_s;
    logic [31:0]       b_r, b_s;
    logic [2:0]        op_r, op_s;
    logic [31:0]       hi_r, hi_s;
    logic [31:0]       lo_r, lo_s;
    logic              done_r, done_s;
    logic              busy_r;
    logic              accept_s;

    logic [63:0]       prod_s;
    logic [31:0]       mag_a_s, mag_b_s;
    logic [31:0]       quo_s, rem_s;
    logic [31:0]       res_hi_s, res_lo_s;
    logic              commit_s;

    // Result datapath: operates only on the operands latched at issue time.
    always_comb begin
        prod_s   = 64'd0;
        quo_s    = 32'd0;
        rem_s    = 32'd0;
        res_hi_s = hi_r;
        res_lo_s = lo_r;
        commit_s = 1'b0;
        mag_a_s  = a_r[31] ? (32'd0 - a_r) : a_r;
        mag_b_s  = b_r[31] ? (32'd0 - b_r) : b_r;
        case (op_r)
            OP_MULT: begin
                prod_s   = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
                commit_s = 1'b1;
            end
            OP_MULTU: begin
                prod_s   = {32'd0, a_r} * {32'd0, b_r};
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
                commit_s = 1'b1;
            end
            OP_DIV: begin
                // Magnitude divide then fix signs; 0x80000000/-1 falls out naturally.
                if (b_r != 32'd0) begin
                    quo_s    = mag_a_s / mag_b_s;
                    rem_s    = mag_a_s % mag_b_s;
                    res_lo_s = (a_r[31] ^ b_r[31]) ? (32'd0 - quo_s) : quo_s;
                    res_hi_s = a_r[31] ? (32'd0 - rem_s) : rem_s;
                    commit_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            OP_DIVU: begin
                if (b_r != 32'd0) begin
                    quo_s    = a_r / b_r;
                    rem_s    = a_r % b_r;
                    res_lo_s = quo_s;
                    res_hi_s = rem_s;
                    commit_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    // Issue acceptance, run counter and HI/LO next-state selection.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        a_s      = a_r;
        b_s      = b_r;
        op_s     = op_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        done_s   = 1'b0;
        accept_s = start && !cancel && (state_r == ST_IDLE) &&
                   (op != 3'd0) && (op != 3'd7);
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_s = ST_RUN;
                            cnt_s   = MULT_CNT;
                            a_s     = a;
                            b_s     = b;
                            op_s    = op;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_s = ST_RUN;
                            cnt_s   = DIV_CNT;
                            a_s     = a;
                            b_s     = b;
                            op_s    = op;
                        end
                        OP_MTHI: hi_s = a;
                        OP_MTLO: lo_s = a;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Further starts are ignored here; the hazard unit stalls them upstream.
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    if (commit_s) begin
                        hi_s = res_hi_s;
                        lo_s = res_lo_s;
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, operand and output registers; reset wins over every other update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            op_r    <= 3'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
            op_r    <= op_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            done_r  <= done_s;
            busy_r  <= (state_s == ST_RUN);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus randomized bench for mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        cancel = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Architectural effect of one accepted operation on HI/LO.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] h_in, input logic [31:0] l_in,
                                  output logic [31:0] h_out, output logic [31:0] l_out);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        logic [63:0] w;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        h_out = h_in;
        l_out = l_in;
        case (o)
            3'd1: begin w = sx * sy; h_out = w[63:32]; l_out = w[31:0]; end
            3'd2: begin w = ux * uy; h_out = w[63:32]; l_out = w[31:0]; end
            3'd3: if (y != 32'd0) begin
                q = sx / sy; r = sx % sy;
                w = q; l_out = w[31:0];
                w = r; h_out = w[31:0];
            end
            3'd4: if (y != 32'd0) begin
                w = ux / uy; l_out = w[31:0];
                w = ux % uy; h_out = w[31:0];
            end
            3'd5: h_out = x;
            3'd6: l_out = x;
            default: ;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return MC;
        if (o == 3'd3 || o == 3'd4) return DC;
        return 0;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] eh, el;
        int n;
        model(o, x, y, exp_hi, exp_lo, eh, el);
        n = latency(o);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; cancel = 1'b0;
        @(negedge clk);
        start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
        for (int i = 0; i < n; i++) begin
            chk1("busy_run", busy, 1'b1);
            chk1("done_early", done, 1'b0);
            chk("hi_hold", hi, exp_hi);
            chk("lo_hold", lo, exp_lo);
            @(negedge clk);
        end
        chk1("busy_end", busy, 1'b0);
        chk1("done_pulse", done, n > 0);
        chk("hi_result", hi, eh);
        chk("lo_result", lo, el);
        exp_hi = eh;
        exp_lo = el;
        @(negedge clk);
        chk1("done_after", done, 1'b0);
        chk1("busy_after", busy, 1'b0);
    endtask

    initial begin
        logic [2:0] ro;
        logic [31:0] rx, ry;

        // reset state
        repeat (2) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0;

        run_op(3'd1, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        run_op(3'd3, 32'hFFFFFFF9, 32'd2);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_lo", lo, 32'hFFFFFFFD);

        run_op(3'd4, 32'd7, 32'd0);
        chk("divz_hi", hi, 32'hFFFFFFFF);
        chk("divz_lo", lo, 32'hFFFFFFFD);

        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        chk("divovf_hi", hi, 32'd0);
        chk("divovf_lo", lo, 32'h80000000);

        // mthi then mtlo back to back
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'h12345678;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h12345678);
        chk1("mthi_busy", busy, 1'b0);
        op = 3'd6; a = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk1("mtlo_busy", busy, 1'b0);
        chk1("mtlo_done", done, 1'b0);
        exp_hi = 32'h12345678;
        exp_lo = 32'h9ABCDEF0;

        // cancelled start
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1("cancel_busy", busy, 1'b0);
            chk1("cancel_done", done, 1'b0);
            chk("cancel_hi", hi, exp_hi);
            chk("cancel_lo", lo, exp_lo);
            @(negedge clk);
        end

        // second start during busy is ignored
        start = 1'b1; op = 3'd2; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < MC; i++) begin
            chk1("ovl_busy", busy, 1'b1);
            if (i == 1) begin
                start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd3;
            end else begin
                start = 1'b0; op = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk1("ovl_busy_end", busy, 1'b0);
        chk1("ovl_done", done, 1'b1);
        chk("ovl_hi", hi, 32'd0);
        chk("ovl_lo", lo, 32'd42);
        exp_hi = 32'd0;
        exp_lo = 32'd42;
        @(negedge clk);
        chk1("ovl_busy_after", busy, 1'b0);

        // op 0 and 7 are no-ops
        run_op(3'd0, 32'h11111111, 32'h2);
        run_op(3'd7, 32'h33333333, 32'h4);

        // reset on the 4th busy cycle of a div
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk1("rstmid_busy4", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk1("rstmid_busy", busy, 1'b0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        for (int i = 0; i < DC; i++) begin
            chk1("rstmid_nodone", done, 1'b0);
            chk("rstmid_hold", hi ^ lo, 32'd0);
            @(negedge clk);
        end

        // randomized operations
        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'd0;
                1: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
                2: ry = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(ro, rx, ry);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
